subleq_core: RTL and testbench

Single-cycle-per-access SUBLEQ execution engine that acts as the initiator on the `mem_op`/`mem_addr`/`mem_write_bytes`/`mem_data` memory bus. It fetches three-word instructions (A, B, C) and reads mem[A] and mem[B]. It writes mem[B] − mem[A] back to B and branches to C when the result is ≤ 0. It sits opposite the word-addressed RAM, which responds on the falling clock edge, and forms the CPU half of the SUBLEQ system.

---
 rtl/subleq_core.sv | 166 ++++++++++++++++
 tb/tb_subleq_core.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_core.sv
// SUBLEQ execution engine: fetches A/B/C, computes mem[B]-mem[A], writes it back to B
// and branches to C on a signed result <= 0. One bus access per cycle, six cycles per instruction.
module subleq_core #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [1:0]  mem_op,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_write_bytes,
   input  logic [63:0] mem_data,
   output logic [63:0] pc,
   output logic        halted,
   output logic [63:0] retired
);

   localparam logic [2:0] S_FA   = 3'd0;
   localparam logic [2:0] S_FB   = 3'd1;
   localparam logic [2:0] S_FC   = 3'd2;
   localparam logic [2:0] S_RA   = 3'd3;
   localparam logic [2:0] S_RB   = 3'd4;
   localparam logic [2:0] S_WR   = 3'd5;
   localparam logic [2:0] S_HALT = 3'd6;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_IDLE  = 2'b10;

   logic [2:0]  state_q,   state_d;
   logic [63:0] pc_q,      pc_d;
   logic [63:0] a_q,       a_d;
   logic [63:0] b_q,       b_d;
   logic [63:0] c_q,       c_d;
   logic [63:0] va_q,      va_d;
   logic [63:0] res_q,     res_d;
   logic [63:0] retired_q, retired_d;
   logic        halted_q,  halted_d;

   logic        branchTaken;
   logic [63:0] nextPc;

   // Signed <= 0 is just "sign bit set or all zero" on the wrapped result.
   always_comb begin
      branchTaken = res_q[63] || (res_q == 64'h0);
      nextPc      = branchTaken ? c_q : (pc_q + 64'd3);
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      va_d      = va_q;
      res_d     = res_q;
      retired_d = retired_q;
      halted_d  = halted_q;
      case (state_q)
         S_FA: begin
            a_d     = mem_data;
            state_d = S_FB;
         end
         S_FB: begin
            b_d     = mem_data;
            state_d = S_FC;
         end
         S_FC: begin
            c_d     = mem_data;
            state_d = S_RA;
         end
         S_RA: begin
            va_d    = mem_data;
            state_d = S_RB;
         end
         S_RB: begin
            res_d   = mem_data - va_q;
            state_d = S_WR;
         end
         S_WR: begin
            retired_d = retired_q + 64'd1;
            pc_d      = nextPc;
            if (nextPc[63]) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else begin
               state_d  = S_FA;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FA;
         pc_q      <= RESET_PC;
         a_q       <= 64'h0;
         b_q       <= 64'h0;
         c_q       <= 64'h0;
         va_q      <= 64'h0;
         res_q     <= 64'h0;
         retired_q <= 64'h0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         va_q      <= va_d;
         res_q     <= res_d;
         retired_q <= retired_d;
         halted_q  <= halted_d;
      end
   end

   // Bus is decoded from registers only; reset gates it idle because the RAM reads on 00.
   always_comb begin
      mem_op          = OP_IDLE;
      mem_addr        = 64'h0;
      mem_write_bytes = 64'h0;
      if (reset) begin
         case (state_q)
            S_FA: begin
               mem_op   = OP_READ;
               mem_addr = pc_q;
            end
            S_FB: begin
               mem_op   = OP_READ;
               mem_addr = pc_q + 64'd1;
            end
            S_FC: begin
               mem_op   = OP_READ;
               mem_addr = pc_q + 64'd2;
            end
            S_RA: begin
               mem_op   = OP_READ;
               mem_addr = a_q;
            end
            S_RB: begin
               mem_op   = OP_READ;
               mem_addr = b_q;
            end
            S_WR: begin
               mem_op          = OP_WRITE;
               mem_addr        = b_q;
               mem_write_bytes = res_q;
            end
            default: begin
               mem_op = OP_IDLE;
            end
         endcase
      end
   end

   assign pc      = pc_q;
   assign halted  = halted_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_subleq_core.sv
// Bench for subleq_core: a falling-edge RAM, directed vector table, reset corner case,
// and random programs compared against a plain SUBLEQ interpreter.
module tb_subleq_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mem_op;
   logic [63:0] mem_addr;
   logic [63:0] mem_write_bytes;
   logic [63:0] mem_data;
   logic [63:0] pc;
   logic        halted;
   logic [63:0] retired;

   int assertCount = 0;
   int failCount   = 0;

   logic [63:0] ram   [256];
   logic [63:0] model [256];

   subleq_core #(.RESET_PC(64'h0)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_op          (mem_op),
      .mem_addr        (mem_addr),
      .mem_write_bytes (mem_write_bytes),
      .mem_data        (mem_data),
      .pc              (pc),
      .halted          (halted),
      .retired         (retired)
   );

   always #5 clk = ~clk;

   // RAM answers on the falling edge; only the low 8 address bits select a word.
   always @(negedge clk) begin
      if (mem_op == 2'b00) begin
         mem_data <= ram[mem_addr[7:0]];
      end else if (mem_op == 2'b01) begin
         ram[mem_addr[7:0]] <= mem_write_bytes;
         if (mem_addr == 64'hff) $display("[TB] console: %0d", $signed(mem_write_bytes));
      end
   end

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic [63:0] va;
      logic [63:0] vb;
      logic [63:0] expData;
      logic [63:0] expPc;
      logic        expHalted;
   } vec_t;

   function automatic logic [7:0] idx(input logic [63:0] x);
      return x[7:0];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkRead(input string name, input logic [63:0] addr);
      checkOutput({name, " op"},   {62'h0, mem_op}, 64'h0);
      checkOutput({name, " addr"}, mem_addr, addr);
      checkOutput({name, " wdat"}, mem_write_bytes, 64'h0);
   endtask

   task automatic checkWrite(input string name, input logic [63:0] addr, input logic [63:0] data);
      checkOutput({name, " op"},   {62'h0, mem_op}, 64'h1);
      checkOutput({name, " addr"}, mem_addr, addr);
      checkOutput({name, " wdat"}, mem_write_bytes, data);
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, " op"},   {62'h0, mem_op}, 64'h2);
      checkOutput({name, " addr"}, mem_addr, 64'h0);
      checkOutput({name, " wdat"}, mem_write_bytes, 64'h0);
   endtask

   task automatic assertReset();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Holds reset two edges, checks the reset state, then releases just after a rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("reset pc", pc, 64'h0);
      checkOutput("reset retired", retired, 64'h0);
      checkOutput("reset halted", {63'h0, halted}, 64'h0);
      checkIdle("reset bus");
      reset = 1'b1;
   endtask

   task automatic clearRam();
      for (int j = 0; j < 256; j++) ram[j] <= 64'h0;
   endtask

   vec_t        vecs [7];
   logic [63:0] expRd [5];
   logic [63:0] mPc, mRet, ma, mb, mc, mRes, w;
   logic        mHalt;
   int          diffs;

   initial begin
      reset = 1'b0;

      vecs[0] = '{64'd3, 64'd4,   64'd6,  64'd5, 64'd5 + 64'd2, 64'd2, 64'd3, 1'b0};
      vecs[1] = '{64'd3, 64'd4,   64'd6,  64'd5, 64'd5, 64'd0, 64'd6, 1'b0};
      vecs[2] = '{64'd3, 64'd4,   64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[3] = '{64'd3, 64'd4,   64'd6,  64'd1, 64'h8000_0000_0000_0000,
                  64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 1'b0};
      vecs[4] = '{64'd3, 64'hff,  64'd9,  64'd4, 64'd10, 64'd6, 64'd3, 1'b0};
      vecs[5] = '{64'd3, 64'd4,   64'd20, 64'd9, 64'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd20, 1'b0};
      vecs[6] = '{64'd4, 64'd4,   64'd30, 64'd9, 64'd9, 64'd0, 64'd30, 1'b0};

      for (int i = 0; i < 7; i++) begin
         assertReset();
         clearRam();
         ram[0]          <= vecs[i].a;
         ram[1]          <= vecs[i].b;
         ram[2]          <= vecs[i].c;
         ram[idx(vecs[i].a)] <= vecs[i].va;
         ram[idx(vecs[i].b)] <= vecs[i].vb;
         applyStimulus();
         expRd[0] = 64'd0;
         expRd[1] = 64'd1;
         expRd[2] = 64'd2;
         expRd[3] = vecs[i].a;
         expRd[4] = vecs[i].b;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkRead($sformatf("vec%0d read%0d", i, k), expRd[k]);
         end
         @(negedge clk);
         checkWrite($sformatf("vec%0d write", i), vecs[i].b, vecs[i].expData);
         @(negedge clk);
         checkOutput($sformatf("vec%0d pc", i), pc, vecs[i].expPc);
         checkOutput($sformatf("vec%0d retired", i), retired, 64'd1);
         checkOutput($sformatf("vec%0d halted", i), {63'h0, halted}, {63'h0, vecs[i].expHalted});
         checkOutput($sformatf("vec%0d ramB", i), ram[idx(vecs[i].b)], vecs[i].expData);
         if (vecs[i].expHalted) begin
            for (int k = 0; k < 20; k++) begin
               @(negedge clk);
               checkOutput($sformatf("vec%0d halt idle%0d", i, k), {62'h0, mem_op}, 64'h2);
            end
            checkOutput($sformatf("vec%0d halt retired", i), retired, 64'd1);
         end
      end

      // Reset pulled during S_RB: bus idles at once and the write to B never happens.
      assertReset();
      clearRam();
      ram[0] <= 64'd3;
      ram[1] <= 64'd4;
      ram[2] <= 64'd6;
      ram[3] <= 64'd5;
      ram[4] <= 64'd7;
      applyStimulus();
      for (int k = 0; k < 4; k++) @(negedge clk);
      @(posedge clk);
      #1;
      checkRead("midrst before", 64'd4);
      reset = 1'b0;
      #1;
      checkIdle("midrst bus");
      checkOutput("midrst retired", retired, 64'd0);
      checkOutput("midrst pc", pc, 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("midrst idle%0d", k), {62'h0, mem_op}, 64'h2);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checkRead("midrst cycle0", 64'd0);
      checkOutput("midrst ramB kept", ram[4], 64'd7);
      for (int k = 1; k < 5; k++) @(negedge clk);
      @(negedge clk);
      checkWrite("midrst redo write", 64'd4, 64'd2);

      // Random programs against a straightforward SUBLEQ interpreter.
      for (int r = 0; r < 8; r++) begin
         assertReset();
         for (int j = 0; j < 256; j++) begin
            if ($urandom_range(0, 15) == 0) w = {56'hFFFF_FFFF_FFFF_FF, 8'($urandom_range(0, 255))};
            else                            w = 64'($urandom_range(0, 255));
            ram[j]   <= w;
            model[j] = w;
         end
         applyStimulus();
         mPc   = 64'h0;
         mRet  = 64'h0;
         mHalt = 1'b0;
         for (int n = 0; n < 40 && !mHalt; n++) begin
            @(negedge clk);
            checkOutput("rnd pc", pc, mPc);
            checkOutput("rnd retired", retired, mRet);
            checkOutput("rnd halted", {63'h0, halted}, 64'h0);
            checkRead("rnd fetchA", mPc);
            ma = model[idx(mPc)];
            mb = model[idx(mPc + 64'd1)];
            mc = model[idx(mPc + 64'd2)];
            @(negedge clk);
            checkRead("rnd fetchB", mPc + 64'd1);
            @(negedge clk);
            checkRead("rnd fetchC", mPc + 64'd2);
            @(negedge clk);
            checkRead("rnd readA", ma);
            @(negedge clk);
            checkRead("rnd readB", mb);
            mRes = model[idx(mb)] - model[idx(ma)];
            @(negedge clk);
            checkWrite("rnd write", mb, mRes);
            model[idx(mb)] = mRes;
            mRet = mRet + 64'd1;
            mPc  = ($signed(mRes) <= 0) ? mc : mPc + 64'd3;
            mHalt = mPc[63];
         end
         @(negedge clk);
         checkOutput("rnd final pc", pc, mPc);
         checkOutput("rnd final retired", retired, mRet);
         checkOutput("rnd final halted", {63'h0, halted}, {63'h0, mHalt});
         if (mHalt) begin
            for (int k = 0; k < 3; k++) begin
               checkIdle("rnd halt bus");
               @(negedge clk);
            end
         end
         diffs = 0;
         for (int j = 0; j < 256; j++) if (ram[j] !== model[j]) diffs++;
         checkOutput("rnd memory image", 64'(diffs), 64'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
